// File: rtl/wb_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_resp_pkg
// Description : Shared types and constants for the Wishbone SRAM responder.
//               wb_req_t is one queued bus request. c_LAT_CNT_W sizes the
//               wait-state counter. c_LATENCY_MAX is the largest LATENCY
//               that the counter can reach.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_resp_pkg;

  localparam int c_ADR_W       = 11;
  localparam int c_DAT_W       = 32;
  localparam int c_SEL_W       = 4;
  localparam int c_LAT_CNT_W   = 4;
  localparam int c_LATENCY_MAX = 15;

  typedef struct packed {
    logic               we;
    logic [c_ADR_W-1:0] adr;
    logic [c_DAT_W-1:0] dat;
    logic [c_SEL_W-1:0] sel;
  } wb_req_t;

endpackage : wb_resp_pkg
`default_nettype wire

// File: rtl/wb_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_req_fifo
// Description : Synchronous FIFO of wb_req_t. Flush has priority over push
//               and pop. A push while full and a pop while empty are ignored.
//               DEPTH must be a power of two and at least 2, so that the
//               pointers wrap naturally.
// Ports       : clk, rst_n   - clock, synchronous active-low reset
//               flush_i      - drop all entries
//               push_i/data_i - write one entry
//               pop_i/data_o - head entry, removed on pop_i
//               count_o      - occupancy, 0..DEPTH
//               full_o/empty_o - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_req_fifo
  import wb_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  wb_req_t                  data_i,
  input  logic                     pop_i,
  output wb_req_t                  data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int c_PTR_W = $clog2(DEPTH);

  wb_req_t            mem_q [DEPTH];
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W:0]   count_q, count_d;
  logic               w_push, w_pop;

  assign full_o  = (count_q == (c_PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + (c_PTR_W+1)'(1);
        2'b01:   count_d = count_q - (c_PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after it is written.
  always_ff @(posedge clk) begin
    if (w_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule : wb_req_fifo
`default_nettype wire

// File: rtl/wb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : wb_sram_responder
// Description : Pipelined Wishbone B4 slave in front of a single-port SRAM.
//               Requests are queued in order. Each request waits LATENCY
//               cycles at the queue head and is then issued to the SRAM. One
//               cycle later it completes with ack, or with err when it is out
//               of range. Dropping wbs_cyc flushes all unissued requests.
// Option      : WB_RESP_RANGE_ERR_EN - when defined, an address >= WORDS
//               completes with err and has no effect. When undefined, the
//               address wraps modulo WORDS, every request is acked and
//               wbs_err is tied low.
// Ports       : clk, rst_n (synchronous, active-low)
//               wbs_cyc/stb/we/adr/dat_w/sel - request inputs
//               wbs_stall - queue full, request not taken
//               wbs_ack/err - single-cycle completions, wbs_dat_r - read data
// Revision    : 1.0 - initial release
// ============================================================================
module wb_sram_responder
  import wb_resp_pkg::*;
#(
  parameter int WORDS      = 1024,
  parameter int LATENCY    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [c_ADR_W-1:0] wbs_adr,
  input  logic [c_DAT_W-1:0] wbs_dat_w,
  output logic [c_DAT_W-1:0] wbs_dat_r,
  input  logic [c_SEL_W-1:0] wbs_sel,
  output logic               wbs_stall,
  input  logic               wbs_cyc,
  input  logic               wbs_stb,
  output logic               wbs_ack,
  input  logic               wbs_we,
  output logic               wbs_err
);

  localparam int c_IDX_W = $clog2(WORDS);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_LAT_CNT_W-1:0] c_LATENCY = c_LAT_CNT_W'(LATENCY);

  wb_req_t              w_req;
  wb_req_t              w_head;
  logic [c_CNT_W-1:0]   w_count;
  logic                 w_full, w_empty;
  logic                 w_accept, w_issue, w_adr_ok;
  logic                 w_wr_en, w_rd_en;
  logic [c_IDX_W-1:0]   w_idx;
  logic [c_ADR_W-1:0]   w_unused_adr;

  logic [c_LAT_CNT_W-1:0] wait_q, wait_d;
  logic                   ack_q, ack_d;
  logic [c_DAT_W-1:0]     dat_q;
  logic [c_DAT_W-1:0]     mem_q [WORDS];

  // ---------------------------------------------------------------- accept
  // Stall comes from the registered count only. A pop in the same cycle does
  // not reopen the slot until the next cycle.
  assign wbs_stall = (w_count == c_CNT_W'(FIFO_DEPTH));
  assign w_accept  = wbs_cyc & wbs_stb & ~wbs_stall;

  assign w_req.we  = wbs_we;
  assign w_req.adr = wbs_adr;
  assign w_req.dat = wbs_dat_w;
  assign w_req.sel = wbs_sel;

  wb_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (~wbs_cyc),
    .push_i  (w_accept & ~w_full),
    .data_i  (w_req),
    .pop_i   (w_issue),
    .data_o  (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // ------------------------------------------------------------ head timer
  // The counter returns to zero on every issue. The next head therefore
  // always starts counting from zero, and an empty queue holds it at zero.
  assign w_issue = wbs_cyc & ~w_empty & (wait_q == c_LATENCY);

  always_comb begin
    wait_d = wait_q;
    if (!wbs_cyc || w_issue || w_empty) wait_d = '0;
    else                                wait_d = wait_q + c_LAT_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end

  // ---------------------------------------------------------- range check
`ifdef WB_RESP_RANGE_ERR_EN
  assign w_adr_ok = (32'(w_head.adr) < 32'(WORDS));
`else
  assign w_adr_ok = 1'b1;
`endif
  // Only the low index bits address the array. The upper bits matter only
  // to the range check.
  assign w_idx        = w_head.adr[c_IDX_W-1:0];
  assign w_unused_adr = w_head.adr;

  assign w_wr_en = w_issue &  w_head.we & w_adr_ok;
  assign w_rd_en = w_issue & ~w_head.we & w_adr_ok;

  // ------------------------------------------------------------------ SRAM
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < c_SEL_W; b++) begin
        if (w_head.sel[b]) mem_q[w_idx][8*b +: 8] <= w_head.dat[8*b +: 8];
      end
    end
  end

  // The synchronous read lands directly in the output register. The data is
  // then valid in the same cycle as the ack, and it holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n)       dat_q <= '0;
    else if (w_rd_en) dat_q <= mem_q[w_idx];
  end
  assign wbs_dat_r = dat_q;

  // -------------------------------------------------------------- response
  always_comb begin
    ack_d = w_issue & w_adr_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ack_q <= 1'b0;
    else        ack_q <= ack_d;
  end

  // A response that was registered just before wbs_cyc drops is masked.
  // The master has already abandoned the cycle.
  assign wbs_ack = ack_q & wbs_cyc;

`ifdef WB_RESP_RANGE_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = w_issue & ~w_adr_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign wbs_err = err_q & wbs_cyc;
`else
  assign wbs_err = 1'b0;
`endif

endmodule : wb_sram_responder
`default_nettype wire

// File: tb/tb_wb_sram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_wb_sram_responder
// Description : Directed bench. It uses three responders with LATENCY 0, 3
//               and 5. They share one bus, and only the selected instance
//               sees wbs_cyc. The range-error behaviour follows
//               WB_RESP_RANGE_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        b_cyc, b_stb, b_we;
  logic [10:0] b_adr;
  logic [31:0] b_dat;
  logic [3:0]  b_sel;
  int          dsel;

  logic [2:0]  cyc_v, stb_v, ack_v, err_v, stall_v;
  logic [31:0] dat_r0, dat_r1, dat_r2;
  logic        m_ack, m_err, m_stall;
  logic [31:0] m_dat;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;

  assign cyc_v[0] = b_cyc & (dsel == 0);
  assign cyc_v[1] = b_cyc & (dsel == 1);
  assign cyc_v[2] = b_cyc & (dsel == 2);
  assign stb_v    = {3{b_stb}} & cyc_v;

  wb_sram_responder #(.WORDS(1024), .LATENCY(0), .FIFO_DEPTH(4)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n), .wbs_adr(b_adr), .wbs_dat_w(b_dat), .wbs_dat_r(dat_r0),
    .wbs_sel(b_sel), .wbs_stall(stall_v[0]), .wbs_cyc(cyc_v[0]), .wbs_stb(stb_v[0]),
    .wbs_ack(ack_v[0]), .wbs_we(b_we), .wbs_err(err_v[0]));

  wb_sram_responder #(.WORDS(1024), .LATENCY(3), .FIFO_DEPTH(4)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .wbs_adr(b_adr), .wbs_dat_w(b_dat), .wbs_dat_r(dat_r1),
    .wbs_sel(b_sel), .wbs_stall(stall_v[1]), .wbs_cyc(cyc_v[1]), .wbs_stb(stb_v[1]),
    .wbs_ack(ack_v[1]), .wbs_we(b_we), .wbs_err(err_v[1]));

  wb_sram_responder #(.WORDS(1024), .LATENCY(5), .FIFO_DEPTH(4)) u_dut_l5 (
    .clk(clk), .rst_n(rst_n), .wbs_adr(b_adr), .wbs_dat_w(b_dat), .wbs_dat_r(dat_r2),
    .wbs_sel(b_sel), .wbs_stall(stall_v[2]), .wbs_cyc(cyc_v[2]), .wbs_stb(stb_v[2]),
    .wbs_ack(ack_v[2]), .wbs_we(b_we), .wbs_err(err_v[2]));

  always_comb begin
    m_dat = dat_r0;
    if (dsel == 1)      m_dat = dat_r1;
    else if (dsel == 2) m_dat = dat_r2;
  end
  assign m_ack   = ack_v[dsel[1:0]];
  assign m_err   = err_v[dsel[1:0]];
  assign m_stall = stall_v[dsel[1:0]];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Response log of the selected instance, sampled mid-cycle.
  typedef struct {
    int          cyc;
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } resp_t;
  resp_t log_q[$];
  logic  stall_seen;

  always @(negedge clk) begin
    if (m_ack === 1'b1 || m_err === 1'b1) log_q.push_back('{cyc_cnt, m_ack, m_err, m_dat});
    if (m_stall === 1'b1) stall_seen = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called right after a clock edge. It holds the request until a cycle
  // with stall low and returns the label of that cycle.
  task automatic drive_req(input logic we, input logic [10:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           output int acc);
    bit done;
    int guard;
    b_cyc = 1'b1; b_stb = 1'b1; b_we = we; b_adr = adr; b_dat = dat; b_sel = sel;
    done = 1'b0; guard = 0; acc = -1;
    while (!done && guard < 50) begin
      @(negedge clk);
      if (m_stall === 1'b0) begin acc = cyc_cnt; done = 1'b1; end
      @(posedge clk); #1;
      guard++;
    end
    b_stb = 1'b0;
    if (!done) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout adr=%0d: got stalled, want accepted", adr);
    end
  endtask

  task automatic wait_resp(input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin @(posedge clk); #1; k++; end
    tick(2);
  endtask

  // Missing responses are padded with an impossible entry, so the checks
  // that follow fail instead of indexing past the end.
  task automatic pad_log(input int n);
    while (log_q.size() < n) log_q.push_back('{-1, 1'bx, 1'bx, 32'hx});
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0; b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    b_adr = '0; b_dat = '0; b_sel = '0; dsel = 0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    n_vec++; if ({ack_v, err_v, stall_v} !== 9'd0) begin n_fail++;
      $display("FAIL reset_flags: got ack=%b err=%b stall=%b want 000 000 000", ack_v, err_v, stall_v); end
    n_vec++; if ({dat_r0, dat_r1, dat_r2} !== 96'd0) begin n_fail++;
      $display("FAIL reset_dat_r: got %h %h %h want 0", dat_r0, dat_r1, dat_r2); end
  endtask

  task automatic test_basic();
    int a1, a2;
    dsel = 0; log_q.delete(); stall_seen = 1'b0;
    drive_req(1'b1, 11'd5, 32'hDEADBEEF, 4'hF, a1);
    drive_req(1'b0, 11'd5, 32'h0, 4'hF, a2);
    wait_resp(2, 20);
    n_vec++; if (log_q.size() !== 2) begin n_fail++;
      $display("FAIL basic_count: got %0d responses want 2", log_q.size()); end
    pad_log(2);
    n_vec++; if (log_q[0].cyc !== a1 + 2 || log_q[0].ack !== 1'b1) begin n_fail++;
      $display("FAIL basic_wr_ack: got cyc %0d ack %b want cyc %0d ack 1", log_q[0].cyc, log_q[0].ack, a1 + 2); end
    n_vec++; if (log_q[0].dat !== 32'h0) begin n_fail++;
      $display("FAIL basic_wr_dat_hold: got %h want 00000000", log_q[0].dat); end
    n_vec++; if (log_q[1].cyc !== a2 + 2 || log_q[1].ack !== 1'b1) begin n_fail++;
      $display("FAIL basic_rd_ack: got cyc %0d ack %b want cyc %0d ack 1", log_q[1].cyc, log_q[1].ack, a2 + 2); end
    n_vec++; if (log_q[1].dat !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL basic_rd_dat: got %h want deadbeef", log_q[1].dat); end
    n_vec++; if (stall_seen !== 1'b0) begin n_fail++;
      $display("FAIL basic_stall: got stall seen %b want 0", stall_seen); end
  endtask

  task automatic test_byte_sel();
    int a;
    dsel = 0; log_q.delete();
    drive_req(1'b1, 11'd7, 32'hFFFFFFFF, 4'hF, a);
    drive_req(1'b1, 11'd7, 32'h11223344, 4'b0101, a);
    drive_req(1'b1, 11'd7, 32'h00000000, 4'b0000, a);
    drive_req(1'b0, 11'd7, 32'h0, 4'hF, a);
    wait_resp(4, 20);
    n_vec++; if (log_q.size() !== 4) begin n_fail++;
      $display("FAIL sel_count: got %0d responses want 4", log_q.size()); end
    pad_log(4);
    n_vec++; if (log_q[2].ack !== 1'b1 || log_q[2].err !== 1'b0) begin n_fail++;
      $display("FAIL sel_zero_ack: got ack %b err %b want 1 0", log_q[2].ack, log_q[2].err); end
    n_vec++; if (log_q[3].dat !== 32'hFF22FF44) begin n_fail++;
      $display("FAIL sel_merge: got %h want ff22ff44", log_q[3].dat); end
  endtask

  task automatic test_back_to_back();
    int a, a0;
    dsel = 1; log_q.delete();
    for (int i = 0; i < 6; i++) drive_req(1'b1, 11'(i), 32'h100 + i, 4'hF, a);
    wait_resp(6, 60);
    log_q.delete(); stall_seen = 1'b0;
    drive_req(1'b0, 11'd0, 32'h0, 4'hF, a0);
    for (int i = 1; i < 6; i++) drive_req(1'b0, 11'(i), 32'h0, 4'hF, a);
    wait_resp(6, 60);
    n_vec++; if (log_q.size() !== 6) begin n_fail++;
      $display("FAIL b2b_count: got %0d responses want 6", log_q.size()); end
    n_vec++; if (stall_seen !== 1'b1) begin n_fail++;
      $display("FAIL b2b_stall: got stall seen %b want 1", stall_seen); end
    pad_log(6);
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (log_q[i].cyc !== a0 + 5 + 4 * i || log_q[i].ack !== 1'b1) begin n_fail++;
        $display("FAIL b2b_timing[%0d]: got cyc %0d ack %b want cyc %0d ack 1", i, log_q[i].cyc, log_q[i].ack, a0 + 5 + 4 * i); end
      n_vec++; if (log_q[i].dat !== 32'h100 + i) begin n_fail++;
        $display("FAIL b2b_data[%0d]: got %h want %h", i, log_q[i].dat, 32'h100 + i); end
    end
  endtask

  task automatic test_range();
    int a;
    dsel = 0; log_q.delete();
    drive_req(1'b1, 11'd6, 32'h66666666, 4'hF, a);
    drive_req(1'b0, 11'd6, 32'h0, 4'hF, a);
    wait_resp(2, 20);
    log_q.delete();
    drive_req(1'b0, 11'd1030, 32'h0, 4'hF, a);
    drive_req(1'b1, 11'd1030, 32'hAAAAAAAA, 4'hF, a);
    drive_req(1'b0, 11'd6, 32'h0, 4'hF, a);
    wait_resp(3, 20);
    n_vec++; if (log_q.size() !== 3) begin n_fail++;
      $display("FAIL range_count: got %0d responses want 3", log_q.size()); end
    pad_log(3);
`ifdef WB_RESP_RANGE_ERR_EN
    n_vec++; if (log_q[0].err !== 1'b1 || log_q[0].ack !== 1'b0) begin n_fail++;
      $display("FAIL range_rd_err: got err %b ack %b want 1 0", log_q[0].err, log_q[0].ack); end
    n_vec++; if (log_q[0].dat !== 32'h66666666) begin n_fail++;
      $display("FAIL range_rd_hold: got %h want 66666666", log_q[0].dat); end
    n_vec++; if (log_q[1].err !== 1'b1 || log_q[1].ack !== 1'b0) begin n_fail++;
      $display("FAIL range_wr_err: got err %b ack %b want 1 0", log_q[1].err, log_q[1].ack); end
    n_vec++; if (log_q[2].ack !== 1'b1 || log_q[2].dat !== 32'h66666666) begin n_fail++;
      $display("FAIL range_no_write: got ack %b dat %h want 1 66666666", log_q[2].ack, log_q[2].dat); end
`else
    n_vec++; if (log_q[0].ack !== 1'b1 || log_q[0].err !== 1'b0 || log_q[0].dat !== 32'h66666666) begin n_fail++;
      $display("FAIL wrap_rd: got ack %b err %b dat %h want 1 0 66666666", log_q[0].ack, log_q[0].err, log_q[0].dat); end
    n_vec++; if (log_q[1].ack !== 1'b1 || log_q[1].err !== 1'b0) begin n_fail++;
      $display("FAIL wrap_wr_ack: got ack %b err %b want 1 0", log_q[1].ack, log_q[1].err); end
    n_vec++; if (log_q[2].ack !== 1'b1 || log_q[2].dat !== 32'hAAAAAAAA) begin n_fail++;
      $display("FAIL wrap_alias: got ack %b dat %h want 1 aaaaaaaa", log_q[2].ack, log_q[2].dat); end
`endif
  endtask

  // The first scenario drops cyc before any issue. The second drops it in
  // the cycle where the first write's ack would appear, so that write stays
  // committed.
  task automatic test_abort();
    int a, a0, r0;
    logic [31:0] exp0;
    dsel = 2; log_q.delete();
    for (int i = 0; i < 3; i++) drive_req(1'b1, 11'(20 + i), 32'hA0 + i, 4'hF, a);
    wait_resp(3, 40);
    for (int s = 0; s < 2; s++) begin
      log_q.delete();
      drive_req(1'b1, 11'd20, (s == 0) ? 32'hB0 : 32'hC0, 4'hF, a0);
      drive_req(1'b1, 11'd21, (s == 0) ? 32'hB1 : 32'hC1, 4'hF, a);
      drive_req(1'b1, 11'd22, (s == 0) ? 32'hB2 : 32'hC2, 4'hF, a);
      tick((s == 0) ? 1 : 4);
      b_cyc = 1'b0;
      tick(1);
      b_cyc = 1'b1;
      tick(20);
      n_vec++; if (log_q.size() !== 0) begin n_fail++;
        $display("FAIL abort%0d_no_resp: got %0d responses want 0", s, log_q.size()); end
      log_q.delete();
      drive_req(1'b0, 11'd20, 32'h0, 4'hF, r0);
      drive_req(1'b0, 11'd21, 32'h0, 4'hF, a);
      drive_req(1'b0, 11'd22, 32'h0, 4'hF, a);
      wait_resp(3, 40);
      pad_log(3);
      exp0 = (s == 0) ? 32'hA0 : 32'hC0;
      n_vec++; if (log_q[0].cyc !== r0 + 7) begin n_fail++;
        $display("FAIL abort%0d_empty_q: got first ack cyc %0d want %0d", s, log_q[0].cyc, r0 + 7); end
      n_vec++; if (log_q[0].dat !== exp0) begin n_fail++;
        $display("FAIL abort%0d_adr20: got %h want %h", s, log_q[0].dat, exp0); end
      n_vec++; if (log_q[1].dat !== 32'hA1 || log_q[2].dat !== 32'hA2) begin n_fail++;
        $display("FAIL abort%0d_discard: got %h %h want a1 a2", s, log_q[1].dat, log_q[2].dat); end
    end
  endtask

  task automatic test_reset_mid();
    int a, r;
    dsel = 1; log_q.delete();
    drive_req(1'b0, 11'd0, 32'h0, 4'hF, a);
    drive_req(1'b0, 11'd1, 32'h0, 4'hF, a);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    n_vec++; if ({ack_v[1], err_v[1], stall_v[1]} !== 3'b000 || dat_r1 !== 32'h0) begin n_fail++;
      $display("FAIL rstmid_outputs: got ack %b err %b stall %b dat %h want 0 0 0 0", ack_v[1], err_v[1], stall_v[1], dat_r1); end
    tick(15);
    n_vec++; if (log_q.size() !== 0) begin n_fail++;
      $display("FAIL rstmid_no_resp: got %0d responses want 0", log_q.size()); end
    log_q.delete();
    drive_req(1'b0, 11'd2, 32'h0, 4'hF, r);
    wait_resp(1, 20);
    pad_log(1);
    n_vec++; if (log_q[0].cyc !== r + 5 || log_q[0].dat !== 32'h102) begin n_fail++;
      $display("FAIL rstmid_after: got cyc %0d dat %h want cyc %0d dat 00000102", log_q[0].cyc, log_q[0].dat, r + 5); end
  endtask

  initial begin
    stall_seen = 1'b0;
    test_reset();
    test_basic();
    test_byte_sel();
    test_back_to_back();
    test_range();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_wb_sram_responder
`default_nettype wire

// File: doc/wb_sram_responder.md
# wb_sram_responder

Pipelined Wishbone B4 responder fronting a local single-port SRAM. It is the slave end of the bus driven by the DMA core's Wishbone master. It also serves as a bench and system target for any 32-bit pipelined master. Accepted requests are queued in order, and each one waits a programmable number of wait states. The block then returns ack, or err for an out-of-range address. It asserts stall when its queue is full.

## Interface
- WORDS, 1024: SRAM depth in 32-bit words; power of two.
- LATENCY, 0: extra wait states per request, counted once the request reaches the queue head; range 0..15.
- FIFO_DEPTH, 4: request queue depth; power of two, ≥2.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wbs_adr  in  11  word address.
- wbs_dat_w  in  32  write data.
- wbs_dat_r  out  32  read data; valid with wbs_ack.
- wbs_sel  in  4  byte enables.
- wbs_stall  out  1  request-not-accepted indication.
- wbs_cyc  in  1  bus cycle.
- wbs_stb  in  1  request strobe.
- wbs_ack  out  1  single-cycle completion.
- wbs_we  in  1  write.
- wbs_err  out  1  single-cycle error completion.

## Operation
- Accept: a request is accepted in a cycle when wbs_cyc & wbs_stb & !wbs_stall. The tuple {we, adr, dat_w, sel} is pushed to the request FIFO.
- Stall: wbs_stall = (count == FIFO_DEPTH). It is combinational from the registered count only, with no pop look-ahead. A full FIFO therefore never receives a push.
- Head service:
  - A wait counter clears whenever a new entry becomes head.
  - The counter increments each cycle while the head is present.
  - When counter == LATENCY, the head is issued to the SRAM and popped in the same cycle.
- Issue of a write: bytes with wbs_sel[i]=1 are written. sel=0000 is still acked, with no change to memory.
- Issue of a read: the SRAM is read synchronously.
- Response: the cycle after issue, exactly one of wbs_ack / wbs_err pulses for one cycle.
- wbs_dat_r loads the SRAM read data on a read ack. It holds its value at all other times.
- Responses are strictly in acceptance order, at most one per cycle.
- Range check: a request with adr ≥ WORDS completes with err, performs no write, and leaves dat_r unchanged.
- Abort: if wbs_cyc is low in any cycle, the FIFO is flushed and the wait counter cleared. Any response already registered for that cycle is suppressed. Unissued writes are discarded; issued writes stay committed.
- Count arithmetic:
  - Count is log2(FIFO_DEPTH)+1 bits.
  - Push and pop in the same cycle leave count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: wbs_ack=0, wbs_err=0, wbs_stall=0, wbs_dat_r=0. FIFO empty, wait counter 0. SRAM contents are not reset.
- Reset asserted mid-operation behaves as an abort: no responses for outstanding requests.
- Latency for a request accepted in cycle N into an empty queue:
  - Head in N+1.
  - Issue in N+1+LATENCY.
  - ack/err in N+2+LATENCY.
- Throughput: one response per LATENCY+1 cycles sustained. For LATENCY=0 that is one per cycle with no stall.
- Simultaneous events:
  - Issue of a write to address A in the same cycle as a new accept of a read to A: the read returns the new data, because issue order is preserved.
  - Push while count == FIFO_DEPTH-1 with a simultaneous pop: count stays FIFO_DEPTH-1 and stall stays 0.

## Configuration
- WB_RESP_RANGE_ERR_EN defined: the out-of-range check is active as described above.
- WB_RESP_RANGE_ERR_EN undefined:
  - wbs_err is tied 0.
  - The address is truncated to log2(WORDS) bits, so accesses wrap modulo WORDS.
  - Every request is acked.

## Structure
- Package wb_resp_pkg holds:
  - wb_req_t, a packed struct {we, adr[10:0], dat[31:0], sel[3:0]};
  - the LATENCY counter width constant;
  - the maximum-LATENCY constant (15).
- Sub-module wb_req_fifo: a generic synchronous FIFO of wb_req_t with push, pop, flush, count, full and empty.
- The SRAM is inferred in the top with per-byte write enables. The top also holds the wait counter and the response register.

## Test plan
- LATENCY=0, single write 0xDEADBEEF to adr 5 with sel=1111, then read adr 5 → both ack 2 cycles after accept; dat_r=0xDEADBEEF; stall never 1.
- LATENCY=3, FIFO_DEPTH=4, 6 back-to-back reads → stall=1 once 4 are queued; acks spaced 4 cycles apart, in order; all 6 complete.
- Write 0x11223344 to adr 7 with sel=0101 over prior 0xFFFFFFFF, then read → 0xFF22FF44.
- WB_RESP_RANGE_ERR_EN defined, WORDS=1024:
  - read adr 1030 → err, no ack, dat_r unchanged;
  - write adr 1030 with data 0xAAAAAAAA → err; a subsequent read of adr 6 is unchanged.
- LATENCY=5, queue 3 writes, drop wbs_cyc 2 cycles after the last accept → no ack/err thereafter; only writes already issued appear in memory; count=0.
- Assert rst_n=0 for one cycle with 2 requests queued → outputs at reset values next cycle; later traffic behaves normally; SRAM data is retained.
